// File: rtl/cla_add_sched.sv
// cla_add_sched: two-requester, byte-serial scheduler for a shared 8-bit
// carry-lookahead adder. Requesters are arbitrated round-robin. The accepted
// operands are then added least-significant byte first over NBYTES cycles.
// The W-bit sum and the carry-out are returned on a valid/ready channel
// together with the id of the requester that issued the operation.
//
// Ports:
//   i_clk                      clock, all state updates on the rising edge
//   i_rst                      synchronous active-high reset
//   i_req0_valid/o_req0_ready  requester 0 handshake
//   i_req0_a/_b/_cin           requester 0 operands, sampled on accept only
//   i_req1_*/o_req1_ready      same, for requester 1
//   o_rsp_valid/i_rsp_ready    response handshake
//   o_rsp_sum/_cout/_id        a + b + cin (mod 2^W), carry out, requester id
//
// Also contains cla_8, the 8-bit carry-lookahead adder that the scheduler
// time-shares across the operand bytes.

module cla_8 (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_cin,
    output logic [7:0] o_sum,
    output logic       o_cout
);
    logic [7:0] w_g;
    logic [7:0] w_p;
    logic [8:0] w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // Each carry is a flat sum of products over generate/propagate terms,
    // so no carry depends on the previous carry's result.
    always_comb begin
        logic v_term;
        logic v_c;
        w_c    = '0;
        w_c[0] = i_cin;
        for (int i = 0; i < 8; i++) begin
            v_term = i_cin;
            for (int j = 0; j <= i; j++) v_term = v_term & w_p[j];
            v_c = v_term;
            for (int j = 0; j <= i; j++) begin
                v_term = w_g[j];
                for (int k = j + 1; k <= i; k++) v_term = v_term & w_p[k];
                v_c = v_c | v_term;
            end
            w_c[i+1] = v_c;
        end
    end

    assign o_sum  = w_p ^ w_c[7:0];
    assign o_cout = w_c[8];
endmodule

module cla_add_sched #(
    parameter  int NBYTES = 4,
    localparam int W      = 8 * NBYTES,
    localparam int IW     = $clog2(NBYTES + 1)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_req0_valid,
    output logic         o_req0_ready,
    input  logic [W-1:0] i_req0_a,
    input  logic [W-1:0] i_req0_b,
    input  logic         i_req0_cin,
    input  logic         i_req1_valid,
    output logic         o_req1_ready,
    input  logic [W-1:0] i_req1_a,
    input  logic [W-1:0] i_req1_b,
    input  logic         i_req1_cin,
    output logic         o_rsp_valid,
    input  logic         i_rsp_ready,
    output logic [W-1:0] o_rsp_sum,
    output logic         o_rsp_cout,
    output logic         o_rsp_id
);
    // state | meaning
    // IDLE  | waiting for a request, readies driven from the grant
    // RUN   | adding byte r_idx, one byte per cycle
    // DONE  | result held on the response channel until taken
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_carry;
    logic [IW-1:0]   r_idx;
    logic            r_id;
    logic            r_prio;
    logic [W-1:0]    r_sum;
    logic            r_cout;
    logic            r_rsp_valid;

    logic            w_grant;
    logic            w_idle;
    logic            w_accept;
    logic            w_last;
    logic [7:0]      w_a_byte;
    logic [7:0]      w_b_byte;
    logic [7:0]      w_sum_byte;
    logic            w_cout_byte;

    // Contention goes to r_prio; otherwise the only valid requester wins,
    // which lets a lone requester be served back-to-back.
    assign w_grant      = (i_req0_valid && i_req1_valid) ? r_prio : i_req1_valid;
    assign w_idle       = (r_state == S_IDLE) && !i_rst;
    assign o_req0_ready = w_idle && !w_grant;
    assign o_req1_ready = w_idle && w_grant;
    assign w_accept     = (i_req0_valid && o_req0_ready) || (i_req1_valid && o_req1_ready);
    assign w_last       = (r_idx == IW'(NBYTES - 1));

    always_comb begin
        w_a_byte = '0;
        w_b_byte = '0;
        for (int k = 0; k < NBYTES; k++) begin
            if (r_idx == IW'(k)) begin
                w_a_byte = r_a[8*k +: 8];
                w_b_byte = r_b[8*k +: 8];
            end
        end
    end

    cla_8 u_cla (
        .i_a    (w_a_byte),
        .i_b    (w_b_byte),
        .i_cin  (r_carry),
        .o_sum  (w_sum_byte),
        .o_cout (w_cout_byte)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)    w_state_nxt = S_RUN;
            S_RUN:   if (w_last)      w_state_nxt = S_DONE;
            S_DONE:  if (i_rsp_ready) w_state_nxt = S_IDLE;
            default:                  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_id        <= 1'b0;
            r_prio      <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a     <= w_grant ? i_req1_a   : i_req0_a;
                        r_b     <= w_grant ? i_req1_b   : i_req0_b;
                        r_carry <= w_grant ? i_req1_cin : i_req0_cin;
                        r_idx   <= '0;
                        r_id    <= w_grant;
                        r_prio  <= ~w_grant;
                    end
                end
                S_RUN: begin
                    for (int k = 0; k < NBYTES; k++) begin
                        if (r_idx == IW'(k)) r_sum[8*k +: 8] <= w_sum_byte;
                    end
                    r_carry <= w_cout_byte;
                    r_idx   <= r_idx + IW'(1);
                    if (w_last) begin
                        r_cout      <= w_cout_byte;
                        r_rsp_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (i_rsp_ready) r_rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_sum   = r_sum;
    assign o_rsp_cout  = r_cout;
    assign o_rsp_id    = r_id;
endmodule

// File: tb/tb_cla_add_sched.sv
// Bench for cla_add_sched: a 4-byte and a 1-byte instance share one stimulus
// stream and are each compared every cycle against a transaction-level model
// (busy flag, cycles since accept, round-robin priority, sum from arithmetic).
module tb_cla_add_sched;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, v0, v1, rr, c0, c1;
    logic [31:0] a0, b0, a1, b1;

    logic        rdy0_a, rdy1_a, vld_a, cout_a, id_a;
    logic [31:0] sum_a;
    logic        rdy0_b, rdy1_b, vld_b, cout_b, id_b;
    logic [7:0]  sum_b;

    cla_add_sched #(.NBYTES(4)) u_dut4 (
        .i_clk(clk), .i_rst(rst),
        .i_req0_valid(v0), .o_req0_ready(rdy0_a), .i_req0_a(a0), .i_req0_b(b0), .i_req0_cin(c0),
        .i_req1_valid(v1), .o_req1_ready(rdy1_a), .i_req1_a(a1), .i_req1_b(b1), .i_req1_cin(c1),
        .o_rsp_valid(vld_a), .i_rsp_ready(rr), .o_rsp_sum(sum_a), .o_rsp_cout(cout_a), .o_rsp_id(id_a)
    );

    cla_add_sched #(.NBYTES(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst),
        .i_req0_valid(v0), .o_req0_ready(rdy0_b), .i_req0_a(a0[7:0]), .i_req0_b(b0[7:0]), .i_req0_cin(c0),
        .i_req1_valid(v1), .o_req1_ready(rdy1_b), .i_req1_a(a1[7:0]), .i_req1_b(b1[7:0]), .i_req1_cin(c1),
        .o_rsp_valid(vld_b), .i_rsp_ready(rr), .o_rsp_sum(sum_b), .o_rsp_cout(cout_b), .o_rsp_id(id_b)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // transaction-level model, one entry per instance
    bit          m_busy [2];
    int          m_age  [2];
    bit          m_prio [2];
    logic [31:0] m_sum  [2];
    bit          m_cout [2];
    bit          m_id   [2];
    bit          m_was_rst = 1'b1;
    int          nb     [2] = '{4, 1};
    int          acc_ids[$];

    // Called right after a negedge with inputs already driven: checks outputs,
    // advances the model across the coming rising edge, waits for next negedge.
    task automatic cyc();
        logic        o_r0 [2];
        logic        o_r1 [2];
        logic        o_v  [2];
        logic        o_c  [2];
        logic        o_i  [2];
        logic [31:0] o_s  [2];
        bit          g, done;
        logic [32:0] full;
        logic [31:0] ea, eb;
        bit          ec;
        #1;
        o_r0[0] = rdy0_a; o_r1[0] = rdy1_a; o_v[0] = vld_a; o_c[0] = cout_a; o_i[0] = id_a; o_s[0] = sum_a;
        o_r0[1] = rdy0_b; o_r1[1] = rdy1_b; o_v[1] = vld_b; o_c[1] = cout_b; o_i[1] = id_b; o_s[1] = {24'h0, sum_b};
        for (int d = 0; d < 2; d++) begin
            g    = (v0 && v1) ? m_prio[d] : v1;
            done = m_busy[d] && (m_age[d] >= nb[d]);
            chk($sformatf("d%0d_ready0", d), 64'(o_r0[d]), 64'(!rst && !m_busy[d] && !g));
            chk($sformatf("d%0d_ready1", d), 64'(o_r1[d]), 64'(!rst && !m_busy[d] && g));
            chk($sformatf("d%0d_rsp_valid", d), 64'(o_v[d]), 64'(done));
            if (done) begin
                chk($sformatf("d%0d_rsp_sum", d), 64'(o_s[d]), 64'(m_sum[d]));
                chk($sformatf("d%0d_rsp_cout", d), 64'(o_c[d]), 64'(m_cout[d]));
                chk($sformatf("d%0d_rsp_id", d), 64'(o_i[d]), 64'(m_id[d]));
            end else if (m_was_rst) begin
                chk($sformatf("d%0d_rst_sum", d), 64'(o_s[d]), 64'd0);
                chk($sformatf("d%0d_rst_cout", d), 64'(o_c[d]), 64'd0);
                chk($sformatf("d%0d_rst_id", d), 64'(o_i[d]), 64'd0);
            end
            if (rst) begin
                m_busy[d] = 1'b0;
                m_prio[d] = 1'b0;
                m_age[d]  = 0;
            end else if (!m_busy[d]) begin
                if (v0 || v1) begin
                    ea = g ? a1 : a0;
                    eb = g ? b1 : b0;
                    ec = g ? c1 : c0;
                    if (d == 0) begin
                        full      = 33'(ea) + 33'(eb) + 33'(ec);
                        m_sum[d]  = full[31:0];
                        m_cout[d] = full[32];
                        acc_ids.push_back(int'(g));
                    end else begin
                        full      = 33'(ea[7:0]) + 33'(eb[7:0]) + 33'(ec);
                        m_sum[d]  = {24'h0, full[7:0]};
                        m_cout[d] = full[8];
                    end
                    m_id[d]   = g;
                    m_busy[d] = 1'b1;
                    m_age[d]  = 0;
                    m_prio[d] = ~g;
                end
            end else if (done && rr) begin
                m_busy[d] = 1'b0;
            end else if (!done) begin
                m_age[d]++;
            end
        end
        m_was_rst = rst;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        v0 = 1'b0; v1 = 1'b0;
    endtask

    task automatic wait_idle();
        idle_inputs();
        for (int i = 0; i < 20 && (m_busy[0] || m_busy[1]); i++) cyc();
        chk("wait_idle_timeout", 64'(m_busy[0] || m_busy[1]), 64'd0);
    endtask

    task automatic rand_ops();
        a0 = $urandom; b0 = $urandom; c0 = 1'($urandom);
        a1 = $urandom; b1 = $urandom; c1 = 1'($urandom);
    endtask

    initial begin
        rst = 1'b1; rr = 1'b1; idle_inputs();
        a0 = '0; b0 = '0; c0 = 1'b0; a1 = '0; b1 = '0; c1 = 1'b0;
        @(negedge clk);
        cyc(); cyc();
        rst = 1'b0;

        // carry wrap
        v0 = 1'b1; a0 = 32'hFFFF_FFFF; b0 = 32'h0000_0001; c0 = 1'b0;
        cyc();
        wait_idle();

        // carry-in propagation from requester 1
        v1 = 1'b1; a1 = 32'h0000_00FF; b1 = 32'h0000_0001; c1 = 1'b1;
        cyc();
        wait_idle();

        // single-byte corner
        v0 = 1'b1; a0 = 32'h0000_0080; b0 = 32'h0000_0080; c0 = 1'b1;
        cyc();
        wait_idle();

        // round-robin from reset
        rst = 1'b1; cyc(); rst = 1'b0;
        acc_ids.delete();
        for (int i = 0; i < 30; i++) begin
            v0 = 1'b1; v1 = 1'b1; rand_ops();
            cyc();
        end
        chk("arb_accepts", 64'(acc_ids.size() >= 4), 64'd1);
        for (int i = 0; i < acc_ids.size(); i++) chk("arb_alternate", 64'(acc_ids[i]), 64'(i % 2));

        // lone requester 0 repeatedly
        wait_idle();
        acc_ids.delete();
        for (int i = 0; i < 24; i++) begin
            v0 = 1'b1; v1 = 1'b0; rand_ops();
            cyc();
        end
        chk("lone_accepts", 64'(acc_ids.size() >= 3), 64'd1);
        foreach (acc_ids[i]) chk("lone_grant", 64'(acc_ids[i]), 64'd0);

        // backpressure with both requesters waiting
        wait_idle();
        rr = 1'b0;
        v0 = 1'b1; rand_ops();
        cyc();
        idle_inputs();
        for (int i = 0; i < 10 && m_age[0] < 4; i++) cyc();
        for (int i = 0; i < 6; i++) begin
            v0 = 1'b1; v1 = 1'b1; rand_ops();
            cyc();
        end
        rr = 1'b1;
        for (int i = 0; i < 8; i++) cyc();
        wait_idle();

        // reset at the second RUN cycle
        v0 = 1'b1; a0 = 32'hDEAD_BEEF; b0 = 32'h0123_4567; c0 = 1'b1;
        cyc();
        idle_inputs();
        cyc();
        rst = 1'b1; cyc(); rst = 1'b0;
        for (int i = 0; i < 6; i++) cyc();
        v0 = 1'b1; a0 = 32'h1234_5678; b0 = 32'h1111_1111; c0 = 1'b0;
        cyc();
        wait_idle();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            v0  = ($urandom_range(0, 99) < 60);
            v1  = ($urandom_range(0, 99) < 60);
            rr  = ($urandom_range(0, 99) < 70);
            rst = ($urandom_range(0, 99) < 2);
            rand_ops();
            cyc();
        end
        rst = 1'b0; rr = 1'b1;
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
